// File: rtl/serial_to_parallel_4b_if.sv
// Handshake bundle for the serial-to-parallel receiver: serial bit input side,
// parallel word output side and status.
interface serial_to_parallel_4b_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             msb_first;
  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             overrun;

  modport slave (
    input  start, msb_first, bit_valid, bit_in, data_ready,
    output data_out, data_valid, busy, overrun
  );

  modport master (
    output start, msb_first, bit_valid, bit_in, data_ready,
    input  data_out, data_valid, busy, overrun
  );
endinterface

// File: rtl/serial_to_parallel_4b.sv
// Reassembles a serial carry-out bit stream (LSB- or MSB-first) into WIDTH-bit
// words, delivered over valid/ready with one held-word slot and sticky overrun.
module serial_to_parallel_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_to_parallel_4b_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_next;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             order_q, order_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             slot_free, handshake, last_bit;

  always_comb begin
    handshake    = data_valid_q & bus.data_ready;
    slot_free    = ~data_valid_q | bus.data_ready;
    last_bit     = (cnt_q == CNT_W'(WIDTH - 1));
    sr_next      = order_q ? {sr_q[WIDTH-2:0], bus.bit_in} : {bus.bit_in, sr_q[WIDTH-1:1]};
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    order_d      = order_q;
    overrun_d    = overrun_q;
    data_out_d   = data_out_q;
    // A consumed word frees the slot unless something below reloads it
    data_valid_d = data_valid_q & ~bus.data_ready;

    if (bus.start) begin
      // start (re)opens a frame from any state; a same-cycle bit is dropped
      state_d   = S_SHIFT;
      sr_d      = '0;
      cnt_d     = '0;
      order_d   = bus.msb_first;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (bus.bit_valid) begin
            sr_d = sr_next;
            if (last_bit) begin
              cnt_d = '0;
              if (slot_free) begin
                data_out_d   = sr_next;
                data_valid_d = 1'b1;
              end else begin
                state_d = S_HOLD;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (bus.bit_valid) overrun_d = 1'b1;
          if (handshake) begin
            data_out_d   = sr_q;
            data_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = S_SHIFT;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      order_q      <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      order_q      <= order_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule
